mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single data-memory/device bus between the pipelined CPU's MEM stage and one external burst master, such as a boot loader or DMA engine. The CPU normally owns the bus. The external master receives a burst grant when the CPU is idle or, if compiled in, after it has been starved. While the external master owns the bus, the arbiter raises a stall to the CPU pipeline. The block sits between the CPU's memory port (read/write/address/write-data/read-data) and the memory/peripheral bus.

## Interface
- BURST_MAX, 8: maximum external beats per grant (≥1).
- STARVE_LIMIT, 4: contended cycles after which the external master is forced onto the bus (≥1).
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_mem_read  in  1  CPU MEM-stage read request.
- cpu_mem_write  in  1  CPU MEM-stage write request.
- cpu_addr  in  32  CPU address.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  read data to CPU; equals bus_rdata.
- cpu_stall  out  1  freeze IF/ID/EX/MEM; CPU access not performed this cycle.
- ext_req  in  1  external master requests a beat.
- ext_we  in  1  beat is a write (1) or read (0).
- ext_addr  in  32  external beat address.
- ext_wdata  in  32  external write data.
- ext_last  in  1  current beat is the final one of the burst.
- ext_gnt  out  1  external master owns the bus.
- ext_valid  out  1  one-cycle pulse per completed beat.
- ext_rdata  out  32  registered read data for the beat flagged by ext_valid.
- bus_read  out  1  bus read strobe.
- bus_write  out  1  bus write strobe.
- bus_addr  out  32  bus address.
- bus_wdata  out  32  bus write data.
- bus_rdata  in  32  combinational read data from bus (same cycle).

## Operation
- States: S_CPU (reset state) and S_EXT. ext_gnt = (state == S_EXT), registered Moore output.
- cpu_access = cpu_mem_read | cpu_mem_write. beat = ext_gnt & ext_req.
- S_CPU: bus_* = CPU signals, passed through combinationally. cpu_stall = 0. The external side is ignored.
- S_CPU → S_EXT when ext_req & (~cpu_access | starve_cnt == STARVE_LIMIT). On entry, clear beat_cnt and starve_cnt.
- starve_cnt (S_CPU only): increments when ext_req & cpu_access and the transition is not taken. Saturates at STARVE_LIMIT. Clears when ext_req = 0.
- S_EXT: bus_read = beat & ~ext_we; bus_write = beat & ext_we; bus_addr/bus_wdata = ext signals. cpu_stall = cpu_access. The CPU access is held by the pipeline and replayed later.
- Each beat increments beat_cnt.
- S_EXT → S_CPU after a beat with ext_last = 1, or after a beat with beat_cnt == BURST_MAX-1, or in any cycle with ext_req = 0 (no beat performed).
- ext_valid/ext_rdata: registered. ext_valid <= beat; ext_rdata <= bus_rdata on a read beat, otherwise held.
- If cpu_mem_read and cpu_mem_write are both high, both are forwarded unchanged. Arbitration treats this as one access.

## Timing
- Reset values: state S_CPU, ext_gnt 0, ext_valid 0, ext_rdata 0, beat_cnt 0, starve_cnt 0. cpu_stall 0. bus_* follow the CPU inputs.
- A reset asserted mid-burst aborts the burst next edge. No further beats occur, and ext_valid for the last pre-reset beat is suppressed.
- Grant latency: ext_req at edge N with CPU idle → ext_gnt = 1 in cycle N+1, first beat in N+1.
- Beat read latency: ext_valid and ext_rdata appear one cycle after the beat.
- ext_gnt deasserts in the cycle after the terminating beat. The CPU regains the bus in that same cycle, and cpu_stall drops combinationally.
- Minimum one S_CPU cycle between consecutive external grants.
- After a forced grant, the CPU gets at least STARVE_LIMIT contended cycles before the next forced grant.
- BURST_MAX = 1: every grant lasts exactly one beat.

## Configuration
- ARB_STARVE_GUARD_EN defined: starve_cnt present; forced grant after STARVE_LIMIT contended cycles, as described above.
- Not defined: no starve counter, strict CPU priority. S_CPU → S_EXT only when ext_req & ~cpu_access. STARVE_LIMIT is unused.

## Test plan
- CPU only: 10 alternating reads/writes at 0x10..0x34 with ext_req = 0 → bus mirrors CPU each cycle; cpu_stall and ext_gnt stay 0.
- Idle-CPU burst: ext_req with 3 read beats at 0x100/104/108, ext_last on the third → ext_gnt high for 3 cycles; ext_valid pulses with bus data one cycle after each beat; ext_gnt low on the 4th cycle.
- Burst cap: BURST_MAX = 8, ext_req held with ext_last = 0 → exactly 8 beats; ext_gnt drops, then re-asserts after ≥1 S_CPU cycle.
- Contention (macro on): CPU access every cycle and ext_req held from cycle 0 → ext_gnt rises on cycle 5 (STARVE_LIMIT = 4); cpu_stall = 1 throughout the grant. With the macro off, ext_gnt never rises.
- Early release: ext_req drops during S_EXT after 2 beats → S_CPU next cycle; ext_valid count = 2.
- Reset mid-burst on beat 3 of 5 → next cycle ext_gnt = 0, ext_valid = 0, ext_rdata = 0, and the bus follows the CPU.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the data bus between the CPU MEM stage and one external burst master.
// Define ARB_STARVE_GUARD_EN to force a grant after STARVE_LIMIT contended cycles.
module mem_bus_arbiter #(
  parameter int BURST_MAX    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  input  logic        ext_last,
  output logic        ext_gnt,
  output logic        ext_valid,
  output logic [31:0] ext_rdata,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  localparam logic [0:0] S_CPU = 1'b0;
  localparam logic [0:0] S_EXT = 1'b1;

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);

  logic [0:0]    state_q, state_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          ext_valid_q;
  logic [31:0]   ext_rdata_q;
  logic          cpu_access_s;
  logic          beat_s;
  logic          starve_hit_s;
  logic          enter_s;

  assign cpu_access_s = cpu_mem_read | cpu_mem_write;
  assign ext_gnt      = (state_q == S_EXT);
  assign beat_s       = ext_gnt & ext_req;
  assign enter_s      = (state_q == S_CPU) & ext_req & (~cpu_access_s | starve_hit_s);
  assign ext_valid    = ext_valid_q;
  assign ext_rdata    = ext_rdata_q;
  assign cpu_rdata    = bus_rdata;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_hit_s = (starve_cnt_q == STARVE_MAX);

  // Count contended cycles while the CPU keeps the bus; saturate at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q != S_CPU) begin
      starve_cnt_d = starve_cnt_q;
    end else if (enter_s || !ext_req) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  logic unused_starve_limit_s;

  assign starve_hit_s          = 1'b0;
  assign unused_starve_limit_s = (STARVE_LIMIT > 0);
`endif

  // Ownership FSM and burst beat counter.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_CPU: begin
        if (enter_s) begin
          state_d    = S_EXT;
          beat_cnt_d = '0;
        end else begin
          state_d = S_CPU;
        end
      end
      S_EXT: begin
        if (!ext_req) begin
          state_d = S_CPU;
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (ext_last || (beat_cnt_q == BEAT_LAST)) begin
            state_d = S_CPU;
          end else begin
            state_d = S_EXT;
          end
        end
      end
      default: begin
        state_d    = S_CPU;
        beat_cnt_d = '0;
      end
    endcase
  end

  // Bus ownership mux; the stalled CPU access is replayed by the pipeline later.
  always_comb begin
    if (state_q == S_EXT) begin
      bus_read  = beat_s & ~ext_we;
      bus_write = beat_s & ext_we;
      bus_addr  = ext_addr;
      bus_wdata = ext_wdata;
      cpu_stall = cpu_access_s;
    end else begin
      bus_read  = cpu_mem_read;
      bus_write = cpu_mem_write;
      bus_addr  = cpu_addr;
      bus_wdata = cpu_wdata;
      cpu_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CPU;
      beat_cnt_q  <= '0;
      ext_valid_q <= 1'b0;
      ext_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      ext_valid_q <= beat_s;
      if (beat_s && !ext_we) begin
        ext_rdata_q <= bus_rdata;
      end else begin
        ext_rdata_q <= ext_rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: scoreboard of expected external beats.
module tb_mem_bus_arbiter;

  localparam logic [31:0] RD_KEY = 32'h5A5A_0000;

  logic        clk;
  logic        reset;
  logic        cpu_mem_read, cpu_mem_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_req, ext_we, ext_last;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_gnt, ext_valid;
  logic [31:0] ext_rdata;
  logic        bus_read, bus_write;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int          checks;
  int          errors;
  logic        prev_beat;
  logic [31:0] last_rd;
  logic [32:0] sb_q[$];

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_last(ext_last),
    .ext_gnt(ext_gnt), .ext_valid(ext_valid), .ext_rdata(ext_rdata),
    .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  // Simple memory model: read data is a known function of the address.
  assign bus_rdata = bus_addr ^ RD_KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0;
    ext_req = 1'b0; ext_we = 1'b0; ext_last = 1'b0;
    ext_addr = 32'h0; ext_wdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    cpu_mem_read = 1'b1;
    cpu_addr = 32'h0000_0044;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0", ext_gnt); end
    checks++; if (ext_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ext_valid); end
    checks++; if (ext_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", ext_rdata); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", cpu_stall); end
    checks++;
    if ({bus_read, bus_write, bus_addr} !== {1'b1, 1'b0, 32'h0000_0044}) begin
      errors++; $display("FAIL reset_bus got %b%b %h exp 10 00000044", bus_read, bus_write, bus_addr);
    end
    next_cycle();
    reset = 1'b0;
    drive_idle();
    prev_beat = 1'b0;
    last_rd = 32'h0;
    next_cycle();
  endtask

  task automatic test_cpu_only();
    logic [31:0] a;
    for (int i = 0; i < 10; i++) begin
      a = 32'h10 + 32'(i) * 32'd4;
      cpu_addr = a;
      cpu_mem_read = (i % 2 == 0);
      cpu_mem_write = (i % 2 != 0);
      cpu_wdata = 32'(i) * 32'h1111_1111;
      @(negedge clk);
      checks++;
      if ({bus_read, bus_write, bus_addr, bus_wdata, cpu_stall, ext_gnt} !==
          {cpu_mem_read, cpu_mem_write, a, cpu_wdata, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL cpu_only[%0d] got %b%b %h %h stall=%b gnt=%b exp addr %h", i,
                 bus_read, bus_write, bus_addr, bus_wdata, cpu_stall, ext_gnt, a);
      end
      if (cpu_mem_read) begin
        checks++;
        if (cpu_rdata !== (a ^ RD_KEY)) begin errors++; $display("FAIL cpu_rdata[%0d] got %h exp %h", i, cpu_rdata, a ^ RD_KEY); end
      end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_idle_burst();
    int k, nval;
    logic exp_gnt;
    logic [32:0] e;
    k = 0; nval = 0;
    for (int c = 0; c < 6; c++) begin
      ext_req = (k < 3); ext_we = 1'b0; ext_last = (k == 2);
      ext_addr = 32'h100 + 32'(k) * 32'd4;
      exp_gnt = (c >= 1 && c <= 3);
      @(negedge clk);
      checks++; if (ext_gnt !== exp_gnt) begin errors++; $display("FAIL burst_gnt c%0d got %b exp %b", c, ext_gnt, exp_gnt); end
      checks++; if (ext_valid !== prev_beat) begin errors++; $display("FAIL burst_valid c%0d got %b exp %b", c, ext_valid, prev_beat); end
      if (ext_valid) begin
        nval++; checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL burst_sb c%0d got valid exp none", c); end
        else begin e = sb_q.pop_front(); if (ext_rdata !== e[31:0]) begin errors++; $display("FAIL burst_rdata c%0d got %h exp %h", c, ext_rdata, e[31:0]); end end
      end
      if (exp_gnt && ext_req) begin
        checks++;
        if ({bus_read, bus_write, bus_addr} !== {1'b1, 1'b0, ext_addr}) begin errors++; $display("FAIL burst_bus c%0d got %b%b %h exp 10 %h", c, bus_read, bus_write, bus_addr, ext_addr); end
        last_rd = ext_addr ^ RD_KEY;
        sb_q.push_back({1'b1, last_rd});
        k++;
      end
      prev_beat = exp_gnt && ext_req;
      next_cycle();
    end
    checks++; if (nval != 3) begin errors++; $display("FAIL burst_count got %0d exp 3", nval); end
    drive_idle();
  endtask

  task automatic test_burst_cap();
    int k, nval;
    logic exp_gnt;
    logic [32:0] e;
    k = 0; nval = 0;
    for (int c = 0; c < 15; c++) begin
      ext_req = (c < 12); ext_we = 1'b0; ext_last = 1'b0;
      ext_addr = 32'h200 + 32'(k) * 32'd4;
      exp_gnt = (c >= 1 && c <= 8) || (c >= 10 && c <= 12);
      @(negedge clk);
      checks++; if (ext_gnt !== exp_gnt) begin errors++; $display("FAIL cap_gnt c%0d got %b exp %b", c, ext_gnt, exp_gnt); end
      checks++; if (ext_valid !== prev_beat) begin errors++; $display("FAIL cap_valid c%0d got %b exp %b", c, ext_valid, prev_beat); end
      if (ext_valid) begin
        nval++; checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL cap_sb c%0d got valid exp none", c); end
        else begin e = sb_q.pop_front(); if (ext_rdata !== e[31:0]) begin errors++; $display("FAIL cap_rdata c%0d got %h exp %h", c, ext_rdata, e[31:0]); end end
      end
      if (exp_gnt && ext_req) begin
        last_rd = ext_addr ^ RD_KEY;
        sb_q.push_back({1'b1, last_rd});
        k++;
      end
      prev_beat = exp_gnt && ext_req;
      next_cycle();
    end
    checks++; if (nval != 10) begin errors++; $display("FAIL cap_count got %0d exp 10", nval); end
    drive_idle();
  endtask

  task automatic test_contention();
    int k, nval, exp_nval;
    logic exp_gnt;
    logic [32:0] e;
    k = 0; nval = 0;
    cpu_mem_read = 1'b1;
    cpu_addr = 32'h0000_0040;
    for (int c = 0; c < 17; c++) begin
      ext_req = (c < 14); ext_we = 1'b0; ext_last = 1'b0;
      ext_addr = 32'h400 + 32'(k) * 32'd4;
`ifdef ARB_STARVE_GUARD_EN
      exp_gnt = (c >= 5 && c <= 12);
`else
      exp_gnt = 1'b0;
`endif
      @(negedge clk);
      checks++; if (ext_gnt !== exp_gnt) begin errors++; $display("FAIL cont_gnt c%0d got %b exp %b", c, ext_gnt, exp_gnt); end
      checks++; if (cpu_stall !== exp_gnt) begin errors++; $display("FAIL cont_stall c%0d got %b exp %b", c, cpu_stall, exp_gnt); end
      checks++; if (ext_valid !== prev_beat) begin errors++; $display("FAIL cont_valid c%0d got %b exp %b", c, ext_valid, prev_beat); end
      if (ext_valid) begin
        nval++; checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL cont_sb c%0d got valid exp none", c); end
        else begin e = sb_q.pop_front(); if (ext_rdata !== e[31:0]) begin errors++; $display("FAIL cont_rdata c%0d got %h exp %h", c, ext_rdata, e[31:0]); end end
      end
      if (exp_gnt && ext_req) begin
        checks++;
        if ({bus_read, bus_addr} !== {1'b1, ext_addr}) begin errors++; $display("FAIL cont_bus c%0d got %b %h exp 1 %h", c, bus_read, bus_addr, ext_addr); end
        last_rd = ext_addr ^ RD_KEY;
        sb_q.push_back({1'b1, last_rd});
        k++;
      end else if (!exp_gnt) begin
        checks++;
        if ({bus_read, bus_addr} !== {1'b1, 32'h0000_0040}) begin errors++; $display("FAIL cont_cpu_bus c%0d got %b %h exp 1 00000040", c, bus_read, bus_addr); end
      end
      prev_beat = exp_gnt && ext_req;
      next_cycle();
    end
`ifdef ARB_STARVE_GUARD_EN
    exp_nval = 8;
`else
    exp_nval = 0;
`endif
    checks++; if (nval != exp_nval) begin errors++; $display("FAIL cont_count got %0d exp %0d", nval, exp_nval); end
    drive_idle();
    next_cycle();
  endtask

  task automatic test_early_release();
    int k, nval;
    logic exp_gnt;
    logic [32:0] e;
    k = 0; nval = 0;
    for (int c = 0; c < 6; c++) begin
      ext_req = (c < 3); ext_we = 1'b1; ext_last = 1'b0;
      ext_addr = 32'h500 + 32'(k) * 32'd4;
      ext_wdata = 32'hD000_0000 + 32'(k);
      exp_gnt = (c >= 1 && c <= 3);
      @(negedge clk);
      checks++; if (ext_gnt !== exp_gnt) begin errors++; $display("FAIL rel_gnt c%0d got %b exp %b", c, ext_gnt, exp_gnt); end
      checks++; if (ext_valid !== prev_beat) begin errors++; $display("FAIL rel_valid c%0d got %b exp %b", c, ext_valid, prev_beat); end
      if (ext_valid) begin
        nval++; checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL rel_sb c%0d got valid exp none", c); end
        else begin e = sb_q.pop_front(); if (ext_rdata !== e[31:0]) begin errors++; $display("FAIL rel_rdata_held c%0d got %h exp %h", c, ext_rdata, e[31:0]); end end
      end
      if (exp_gnt && ext_req) begin
        checks++;
        if ({bus_read, bus_write, bus_addr, bus_wdata} !== {1'b0, 1'b1, ext_addr, ext_wdata}) begin
          errors++; $display("FAIL rel_bus c%0d got %b%b %h %h exp 01 %h %h", c, bus_read, bus_write, bus_addr, bus_wdata, ext_addr, ext_wdata);
        end
        sb_q.push_back({1'b0, last_rd});
        k++;
      end else if (exp_gnt) begin
        checks++;
        if ({bus_read, bus_write} !== 2'b00) begin errors++; $display("FAIL rel_nobeat c%0d got %b%b exp 00", c, bus_read, bus_write); end
      end
      prev_beat = exp_gnt && ext_req;
      next_cycle();
    end
    checks++; if (nval != 2) begin errors++; $display("FAIL rel_count got %0d exp 2", nval); end
    drive_idle();
  endtask

  task automatic test_reset_mid_burst();
    int k;
    logic exp_gnt;
    logic [32:0] e;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      ext_req = 1'b1; ext_we = 1'b0; ext_last = (k == 4);
      ext_addr = 32'h600 + 32'(k) * 32'd4;
      reset = (c == 3);
      exp_gnt = (c >= 1);
      @(negedge clk);
      checks++; if (ext_gnt !== exp_gnt) begin errors++; $display("FAIL rst_gnt c%0d got %b exp %b", c, ext_gnt, exp_gnt); end
      checks++; if (ext_valid !== prev_beat) begin errors++; $display("FAIL rst_valid c%0d got %b exp %b", c, ext_valid, prev_beat); end
      if (ext_valid) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL rst_sb c%0d got valid exp none", c); end
        else begin e = sb_q.pop_front(); if (ext_rdata !== e[31:0]) begin errors++; $display("FAIL rst_rdata c%0d got %h exp %h", c, ext_rdata, e[31:0]); end end
      end
      if (exp_gnt && c < 3) begin
        last_rd = ext_addr ^ RD_KEY;
        sb_q.push_back({1'b1, last_rd});
        k++;
      end
      prev_beat = exp_gnt && (c < 3);
      next_cycle();
    end
    reset = 1'b0;
    drive_idle();
    cpu_mem_read = 1'b1;
    cpu_addr = 32'h0000_0300;
    @(negedge clk);
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL rst_after_gnt got %b exp 0", ext_gnt); end
    checks++; if (ext_valid !== 1'b0) begin errors++; $display("FAIL rst_after_valid got %b exp 0", ext_valid); end
    checks++; if (ext_rdata !== 32'h0) begin errors++; $display("FAIL rst_after_rdata got %h exp 0", ext_rdata); end
    checks++;
    if ({bus_read, bus_addr, cpu_stall} !== {1'b1, 32'h0000_0300, 1'b0}) begin
      errors++; $display("FAIL rst_after_bus got %b %h stall=%b exp 1 00000300 0", bus_read, bus_addr, cpu_stall);
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL rst_sb_left got %0d exp 0", sb_q.size()); end
    next_cycle();
    drive_idle();
    next_cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    prev_beat = 1'b0;
    last_rd = 32'h0;
    test_reset();
    test_cpu_only();
    test_idle_burst();
    test_burst_cap();
    test_contention();
    test_early_release();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
